// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the ALU result stage: ALU opcodes, destination selects,
// sequencer states, PSW bit positions and the per-opcode flag-write mask.
package alu_writeback_pkg;

   localparam logic [4:0] ALU_NOP  = 5'd0;
   localparam logic [4:0] ALU_ADD  = 5'd1;
   localparam logic [4:0] ALU_ADDC = 5'd2;
   localparam logic [4:0] ALU_SUBB = 5'd3;
   localparam logic [4:0] ALU_INC  = 5'd4;
   localparam logic [4:0] ALU_DEC  = 5'd5;
   localparam logic [4:0] ALU_ANL  = 5'd6;
   localparam logic [4:0] ALU_ORL  = 5'd7;
   localparam logic [4:0] ALU_XRL  = 5'd8;

   localparam logic [1:0] WB_DST_NONE = 2'b00;
   localparam logic [1:0] WB_DST_ACC  = 2'b01;
   localparam logic [1:0] WB_DST_ACCB = 2'b10;
   localparam logic [1:0] WB_DST_EXT  = 2'b11;

   localparam int PSW_CY = 7;
   localparam int PSW_AC = 6;
   localparam int PSW_OV = 2;
   localparam int PSW_P  = 0;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_HI   = 1'b1
   } wb_state_e;

   // PSW bits [7:1] an ALU result of this opcode overwrites
   function automatic logic [7:1] flag_write_mask(input logic [4:0] opcode);
      logic [7:1] mask;
      mask = '0;
      case (opcode)
         ALU_ADD, ALU_ADDC, ALU_SUBB: begin
            mask[PSW_CY] = 1'b1;
            mask[PSW_AC] = 1'b1;
            mask[PSW_OV] = 1'b1;
         end
         ALU_ORL, ALU_ANL: mask[PSW_CY] = 1'b1;
         default: mask = '0;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/alu_writeback_psw.sv
// PSW storage: merges ALU flag updates with SFR-bus writes and derives parity from ACC.
// ALU_WB_FWD_EN selects whether the carry feedback taps the next-state or the stored flags.
module psw_reg
   import alu_writeback_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic [7:1] alu_flag_we,
   input  logic [7:1] alu_flag_val,
   input  logic       sfr_we,
   input  logic [7:0] sfr_wdata,
   input  logic [7:0] acc,
   output logic [7:0] psw,
   output logic       carry_src,
   output logic       aux_carry_src
);

   logic [7:1] flag_reg;
   logic [7:1] flag_next;

   genvar gi;
   generate
      for (gi = 1; gi < 8; gi++) begin : g_flag
         // ALU has priority; the top never acks a PSW SFR write while the ALU owns flags
         assign flag_next[gi] = alu_flag_we[gi] ? alu_flag_val[gi] :
                                sfr_we          ? sfr_wdata[gi]    : flag_reg[gi];
      end
   endgenerate

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         flag_reg <= '0;
      end else begin
         flag_reg <= flag_next;
      end
   end

   assign psw = {flag_reg, ^acc};

`ifdef ALU_WB_FWD_EN
   assign carry_src     = flag_next[PSW_CY];
   assign aux_carry_src = flag_next[PSW_AC];
`else
   assign carry_src     = flag_reg[PSW_CY];
   assign aux_carry_src = flag_reg[PSW_AC];
`endif

endmodule

// File: rtl/alu_writeback.sv
// 8051 ALU result stage: commits results to ACC/B/PSW or an external direct address,
// splitting 16-bit INC results into two byte writes. ALU_WB_FWD_EN enables carry bypass.
module alu_writeback
   import alu_writeback_pkg::*;
#(
   parameter logic [7:0] ACC_ADDR = 8'hE0,
   parameter logic [7:0] B_ADDR   = 8'hF0,
   parameter logic [7:0] PSW_ADDR = 8'hD0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       alu_valid,
   output logic       wb_ready,
   input  logic [4:0] alu_opcode,
   input  logic [7:0] op_out_1,
   input  logic [7:0] op_out_2,
   input  logic       carry_out,
   input  logic       aux_carry_out,
   input  logic       overflow_out,
   input  logic [1:0] dest_sel,
   input  logic [7:0] dest_addr,
   input  logic       wide,
   input  logic       sfr_wr_en,
   input  logic [7:0] sfr_addr,
   input  logic [7:0] sfr_wdata,
   output logic       sfr_ack,
   output logic       ext_wr_en,
   output logic [7:0] ext_addr,
   output logic [7:0] ext_wdata,
   output logic [7:0] acc,
   output logic [7:0] b_reg,
   output logic [7:0] psw,
   output logic       carry_to_alu,
   output logic       aux_carry_to_alu
);

   wb_state_e  state_reg, state_next;
   logic [7:0] acc_data_reg, acc_data_next;
   logic [7:0] b_data_reg, b_data_next;
   logic       ext_wr_en_reg, ext_wr_en_next;
   logic [7:0] ext_addr_reg, ext_addr_next;
   logic [7:0] ext_wdata_reg, ext_wdata_next;
   logic [7:0] hi_addr_reg, hi_addr_next;
   logic [7:0] hi_data_reg, hi_data_next;

   logic       accept;
   logic       dst_acc, dst_b, dst_ext, wide_start;
   logic [7:1] flag_mask;
   logic [7:1] flag_val;
   logic       sfr_hit_acc, sfr_hit_b, sfr_hit_psw, sfr_conflict;

   assign wb_ready   = (state_reg == S_IDLE);
   assign accept     = alu_valid & wb_ready;
   assign dst_acc    = accept & ((dest_sel == WB_DST_ACC) | (dest_sel == WB_DST_ACCB));
   assign dst_b      = accept & (dest_sel == WB_DST_ACCB);
   assign dst_ext    = accept & (dest_sel == WB_DST_EXT);
   assign wide_start = dst_ext & wide & (alu_opcode == ALU_INC);

   assign flag_mask = accept ? flag_write_mask(alu_opcode) : '0;
   assign flag_val  = {carry_out, aux_carry_out, 3'b000, overflow_out, 1'b0};

   // An SFR write loses only when the ALU commits to the very same register this edge
   assign sfr_hit_acc  = (sfr_addr == ACC_ADDR);
   assign sfr_hit_b    = (sfr_addr == B_ADDR);
   assign sfr_hit_psw  = (sfr_addr == PSW_ADDR);
   assign sfr_conflict = (sfr_hit_acc & dst_acc) | (sfr_hit_b & dst_b) |
                         (sfr_hit_psw & (|flag_mask));
   assign sfr_ack      = sfr_wr_en & ~sfr_conflict;

   always_comb begin
      acc_data_next = acc_data_reg;
      b_data_next   = b_data_reg;
      if (dst_acc) begin
         acc_data_next = op_out_1;
      end else if (sfr_ack && sfr_hit_acc) begin
         acc_data_next = sfr_wdata;
      end
      if (dst_b) begin
         b_data_next = op_out_2;
      end else if (sfr_ack && sfr_hit_b) begin
         b_data_next = sfr_wdata;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: if (wide_start) state_next = S_HI;
         S_HI:   state_next = S_IDLE;
      endcase
   end

   always_comb begin
      ext_wr_en_next = 1'b0;
      ext_addr_next  = ext_addr_reg;
      ext_wdata_next = ext_wdata_reg;
      hi_addr_next   = hi_addr_reg;
      hi_data_next   = hi_data_reg;
      if (state_reg == S_HI) begin
         ext_wr_en_next = 1'b1;
         ext_addr_next  = hi_addr_reg;
         ext_wdata_next = hi_data_reg;
      end else if (dst_ext) begin
         ext_wr_en_next = 1'b1;
         ext_addr_next  = dest_addr;
         ext_wdata_next = op_out_1;
      end
      if (wide_start) begin
         hi_addr_next = dest_addr + 8'd1;
         hi_data_next = op_out_2;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg     <= S_IDLE;
         acc_data_reg  <= '0;
         b_data_reg    <= '0;
         ext_wr_en_reg <= 1'b0;
         ext_addr_reg  <= '0;
         ext_wdata_reg <= '0;
         hi_addr_reg   <= '0;
         hi_data_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         acc_data_reg  <= acc_data_next;
         b_data_reg    <= b_data_next;
         ext_wr_en_reg <= ext_wr_en_next;
         ext_addr_reg  <= ext_addr_next;
         ext_wdata_reg <= ext_wdata_next;
         hi_addr_reg   <= hi_addr_next;
         hi_data_reg   <= hi_data_next;
      end
   end

   psw_reg u_psw (
      .clock         (clock),
      .reset         (reset),
      .alu_flag_we   (flag_mask),
      .alu_flag_val  (flag_val),
      .sfr_we        (sfr_ack & sfr_hit_psw),
      .sfr_wdata     (sfr_wdata),
      .acc           (acc_data_reg),
      .psw           (psw),
      .carry_src     (carry_to_alu),
      .aux_carry_src (aux_carry_to_alu)
   );

   assign acc       = acc_data_reg;
   assign b_reg     = b_data_reg;
   assign ext_wr_en = ext_wr_en_reg;
   assign ext_addr  = ext_addr_reg;
   assign ext_wdata = ext_wdata_reg;

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: behavioural model checked every cycle plus literal pins.
`timescale 1ns/1ps
module tb_alu_writeback;
   import alu_writeback_pkg::*;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       alu_valid = 1'b0;
   logic       wb_ready;
   logic [4:0] alu_opcode = '0;
   logic [7:0] op_out_1 = '0, op_out_2 = '0;
   logic       carry_out = 1'b0, aux_carry_out = 1'b0, overflow_out = 1'b0;
   logic [1:0] dest_sel = '0;
   logic [7:0] dest_addr = '0;
   logic       wide = 1'b0;
   logic       sfr_wr_en = 1'b0;
   logic [7:0] sfr_addr = '0, sfr_wdata = '0;
   logic       sfr_ack, ext_wr_en;
   logic [7:0] ext_addr, ext_wdata, acc, b_reg, psw;
   logic       carry_to_alu, aux_carry_to_alu;

   int total = 0;
   int bad = 0;
   int pin_id = 0;

   always #5 clock = ~clock;

   alu_writeback dut (
      .clock(clock), .reset(reset), .alu_valid(alu_valid), .wb_ready(wb_ready),
      .alu_opcode(alu_opcode), .op_out_1(op_out_1), .op_out_2(op_out_2),
      .carry_out(carry_out), .aux_carry_out(aux_carry_out), .overflow_out(overflow_out),
      .dest_sel(dest_sel), .dest_addr(dest_addr), .wide(wide),
      .sfr_wr_en(sfr_wr_en), .sfr_addr(sfr_addr), .sfr_wdata(sfr_wdata), .sfr_ack(sfr_ack),
      .ext_wr_en(ext_wr_en), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .acc(acc), .b_reg(b_reg), .psw(psw),
      .carry_to_alu(carry_to_alu), .aux_carry_to_alu(aux_carry_to_alu)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model state: architectural registers and the queue of pending external writes
   logic [7:0]  m_acc, m_b, m_flags;
   logic        m_ext_en;
   logic [7:0]  m_ext_addr, m_ext_data;
   logic [15:0] ext_q[$];

   logic [7:0]  n_acc, n_b, n_flags, a1;
   logic        acc_w, b_w, arith, logic_op, m_accept, m_ready, m_ack, conflict;
   logic [15:0] w;

   always @(negedge clock) begin
      if (!reset) begin
         m_acc = '0; m_b = '0; m_flags = '0;
         m_ext_en = 1'b0; m_ext_addr = '0; m_ext_data = '0;
         ext_q.delete();
         chk("rst_acc", 32'(acc), 32'h0);
         chk("rst_b", 32'(b_reg), 32'h0);
         chk("rst_psw", 32'(psw), 32'h0);
         chk("rst_ext_en", 32'(ext_wr_en), 32'h0);
         chk("rst_ext_addr", 32'(ext_addr), 32'h0);
         chk("rst_ext_data", 32'(ext_wdata), 32'h0);
      end else begin
         chk("acc", 32'(acc), 32'(m_acc));
         chk("b_reg", 32'(b_reg), 32'(m_b));
         chk("psw", 32'(psw), 32'({m_flags[7:1], 1'b0} | 8'($countones(m_acc) % 2)));
         chk("ext_wr_en", 32'(ext_wr_en), 32'(m_ext_en));
         chk("ext_addr", 32'(ext_addr), 32'(m_ext_addr));
         chk("ext_wdata", 32'(ext_wdata), 32'(m_ext_data));

         m_ready  = (ext_q.size() == 0);
         m_accept = alu_valid && m_ready;
         arith    = alu_opcode inside {ALU_ADD, ALU_ADDC, ALU_SUBB};
         logic_op = alu_opcode inside {ALU_ORL, ALU_ANL};
         acc_w    = m_accept && (dest_sel == WB_DST_ACC || dest_sel == WB_DST_ACCB);
         b_w      = m_accept && (dest_sel == WB_DST_ACCB);
         conflict = (sfr_addr == 8'hE0 && acc_w) || (sfr_addr == 8'hF0 && b_w) ||
                    (sfr_addr == 8'hD0 && m_accept && (arith || logic_op));
         m_ack    = sfr_wr_en && !conflict;
         chk("wb_ready", 32'(wb_ready), 32'(m_ready));
         chk("sfr_ack", 32'(sfr_ack), 32'(m_ack));

         n_acc = m_acc; n_b = m_b; n_flags = m_flags;
         if (m_ack && sfr_addr == 8'hE0) n_acc = sfr_wdata;
         if (m_ack && sfr_addr == 8'hF0) n_b = sfr_wdata;
         if (m_ack && sfr_addr == 8'hD0) n_flags[7:1] = sfr_wdata[7:1];
         if (acc_w) n_acc = op_out_1;
         if (b_w) n_b = op_out_2;
         if (m_accept && arith) begin
            n_flags[7] = carry_out; n_flags[6] = aux_carry_out; n_flags[2] = overflow_out;
         end
         if (m_accept && logic_op) n_flags[7] = carry_out;

`ifdef ALU_WB_FWD_EN
         chk("carry_to_alu", 32'(carry_to_alu), 32'(n_flags[7]));
         chk("aux_carry_to_alu", 32'(aux_carry_to_alu), 32'(n_flags[6]));
`else
         chk("carry_to_alu", 32'(carry_to_alu), 32'(m_flags[7]));
         chk("aux_carry_to_alu", 32'(aux_carry_to_alu), 32'(m_flags[6]));
`endif

         if (m_accept && dest_sel == WB_DST_EXT) begin
            ext_q.push_back({dest_addr, op_out_1});
            if (wide && alu_opcode == ALU_INC) begin
               a1 = dest_addr + 8'd1;
               ext_q.push_back({a1, op_out_2});
            end
         end
         if (ext_q.size() > 0) begin
            w = ext_q.pop_front();
            m_ext_en = 1'b1; m_ext_addr = w[15:8]; m_ext_data = w[7:0];
         end else begin
            m_ext_en = 1'b0;
         end
         if (m_accept)
            $display("txn t=%0t op=%0d dst=%0d addr=%02h lo=%02h hi=%02h wide=%0b sfr=%0b ack=%0b",
                     $time, alu_opcode, dest_sel, dest_addr, op_out_1, op_out_2, wide, sfr_wr_en, m_ack);
         m_acc = n_acc; m_b = n_b; m_flags = n_flags;
      end

      case (pin_id)
         1: begin
            chk("pin_rst_acc", 32'(acc), 32'h0);
            chk("pin_rst_psw", 32'(psw), 32'h0);
         end
         2: chk("pin_add_ready", 32'(wb_ready), 32'h1);
         3: begin
            chk("pin_add_acc", 32'(acc), 32'h80);
            chk("pin_add_psw", 32'(psw), 32'h45);
            chk("pin_add_ready2", 32'(wb_ready), 32'h1);
         end
         4: chk("pin_inc_ready", 32'(wb_ready), 32'h1);
         5: begin
            chk("pin_lo_en", 32'(ext_wr_en), 32'h1);
            chk("pin_lo_addr", 32'(ext_addr), 32'h82);
            chk("pin_lo_data", 32'(ext_wdata), 32'h00);
            chk("pin_lo_busy", 32'(wb_ready), 32'h0);
         end
         6: begin
            chk("pin_hi_en", 32'(ext_wr_en), 32'h1);
            chk("pin_hi_addr", 32'(ext_addr), 32'h83);
            chk("pin_hi_data", 32'(ext_wdata), 32'h12);
            chk("pin_hi_ready", 32'(wb_ready), 32'h1);
         end
         7: chk("pin_ext_done", 32'(ext_wr_en), 32'h0);
         8: begin
            chk("pin_wrap_en", 32'(ext_wr_en), 32'h1);
            chk("pin_wrap_addr", 32'(ext_addr), 32'h00);
            chk("pin_wrap_data", 32'(ext_wdata), 32'h34);
         end
         9: chk("pin_psw_block", 32'(sfr_ack), 32'h0);
         10: begin
            chk("pin_psw_alu", 32'(psw), 32'h41);
            chk("pin_psw_retry_ack", 32'(sfr_ack), 32'h1);
         end
         11: chk("pin_psw_sfr", 32'(psw), 32'hFF);
`ifdef ALU_WB_FWD_EN
         12: chk("pin_fwd_same", 32'(carry_to_alu), 32'h1);
`else
         12: chk("pin_fwd_same", 32'(carry_to_alu), 32'h0);
`endif
         13: begin
            chk("pin_fwd_next", 32'(carry_to_alu), 32'h1);
            chk("pin_addc_acc", 32'(acc), 32'h03);
            chk("pin_addc_psw", 32'(psw), 32'h80);
         end
         14: begin
            chk("pin_midrst_en", 32'(ext_wr_en), 32'h0);
            chk("pin_midrst_acc", 32'(acc), 32'h0);
            chk("pin_midrst_b", 32'(b_reg), 32'h0);
            chk("pin_midrst_psw", 32'(psw), 32'h0);
         end
         15: begin
            chk("pin_resume_ready", 32'(wb_ready), 32'h1);
            chk("pin_resume_en", 32'(ext_wr_en), 32'h0);
         end
         16: begin
            chk("pin_accb_acc", 32'(acc), 32'h5A);
            chk("pin_accb_b", 32'(b_reg), 32'hC3);
            chk("pin_accb_psw", 32'(psw), 32'h00);
         end
         default: ;
      endcase
   end

   task automatic step();
      @(posedge clock);
      #1;
      pin_id = 0;
   endtask

   task automatic idle();
      alu_valid = 1'b0; sfr_wr_en = 1'b0; wide = 1'b0;
   endtask

   task automatic alu(input logic [4:0] op, input logic [1:0] dst, input logic [7:0] addr,
                      input logic [7:0] lo, input logic [7:0] hi, input logic wd,
                      input logic cy, input logic ac, input logic ov);
      alu_valid = 1'b1; alu_opcode = op; dest_sel = dst; dest_addr = addr;
      op_out_1 = lo; op_out_2 = hi; wide = wd;
      carry_out = cy; aux_carry_out = ac; overflow_out = ov;
   endtask

   task automatic sfr(input logic [7:0] addr, input logic [7:0] data);
      sfr_wr_en = 1'b1; sfr_addr = addr; sfr_wdata = data;
   endtask

   logic [4:0] op_tab [10];
   logic [7:0] sfr_tab [4];

   initial begin
      op_tab = '{ALU_NOP, ALU_ADD, ALU_ADDC, ALU_SUBB, ALU_INC, ALU_DEC,
                 ALU_ANL, ALU_ORL, ALU_XRL, 5'd20};
      sfr_tab = '{8'hE0, 8'hF0, 8'hD0, 8'h90};
      reset = 1'b0;
      step(); pin_id = 1;
      step();
      step(); reset = 1'b1;

      step(); alu(ALU_ADD, WB_DST_ACC, 8'h00, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1); pin_id = 2;
      step(); idle(); pin_id = 3;

      step(); alu(ALU_INC, WB_DST_EXT, 8'h82, 8'h00, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0); pin_id = 4;
      step(); idle(); pin_id = 5;
      step(); pin_id = 6;
      step(); pin_id = 7;

      step(); alu(ALU_INC, WB_DST_EXT, 8'hFF, 8'h56, 8'h34, 1'b1, 1'b0, 1'b0, 1'b0);
      step(); idle();
      step(); pin_id = 8;

      step(); alu(ALU_ADDC, WB_DST_NONE, 8'h00, 8'h11, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      sfr(8'hD0, 8'hFF); pin_id = 9;
      step(); alu_valid = 1'b0; pin_id = 10;
      step(); idle(); pin_id = 11;

      step(); sfr(8'hD0, 8'h00);
      step(); idle(); alu(ALU_ADDC, WB_DST_ACC, 8'h00, 8'h03, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      pin_id = 12;
      step(); idle(); pin_id = 13;

      step(); alu(ALU_INC, WB_DST_EXT, 8'h10, 8'hBB, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
      step(); idle(); reset = 1'b0; pin_id = 14;
      step(); reset = 1'b1; pin_id = 15;

      step(); alu(ALU_XRL, WB_DST_ACCB, 8'h00, 8'h5A, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b1);
      step(); idle(); pin_id = 16;

      for (int i = 0; i < 800; i++) begin
         step();
         if ($urandom_range(0, 249) == 0) begin
            idle(); reset = 1'b0;
            step(); reset = 1'b1;
         end else begin
            alu_valid     = ($urandom_range(0, 2) != 0);
            alu_opcode    = ($urandom_range(0, 3) == 0) ? ALU_INC : op_tab[$urandom_range(0, 9)];
            dest_sel      = 2'($urandom_range(0, 3));
            dest_addr     = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            op_out_1      = 8'($urandom);
            op_out_2      = 8'($urandom);
            wide          = 1'($urandom);
            carry_out     = 1'($urandom);
            aux_carry_out = 1'($urandom);
            overflow_out  = 1'($urandom);
            sfr_wr_en     = 1'($urandom);
            sfr_addr      = sfr_tab[$urandom_range(0, 3)];
            sfr_wdata     = 8'($urandom);
         end
      end

      step(); idle();
      step();
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
      $fatal(1, "watchdog");
   end

endmodule
